wash_countdown_timer: RTL and testbench

- Downstream consumer of the clock-enable tick generator; a loadable seconds countdown that sequences each dishwasher phase (prewash, wash, rinse, dry).
- Counts down only on single-cycle `tick` strobes and drives `tick_en` back to the tick generator's enable input.
- Reports run/pause status, a one-cycle `done` pulse and minute/second display values for the panel driver.

---
 rtl/wash_pkg.sv | 23 ++
 rtl/wash_countdown_timer_if.sv | 39 +++
 rtl/wash_countdown_timer_sec_to_mmss.sv | 25 ++
 rtl/wash_countdown_timer.sv | 102 ++++++++++
 tb/tb_wash_countdown_timer.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/wash_pkg.sv
// Shared types and constants for the wash countdown timer and its panel/sequencer neighbours.
// Pure definitions: no latency, no flow control.
package wash_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int MAX_SEC_DEF  = 5999;
    localparam int SEC_W_DEF    = $clog2(MAX_SEC_DEF + 1);
    localparam int SEC_PER_MIN  = 60;
    localparam int WARN_SEC_DEF = 10;

    // Phase durations in seconds, loaded one by one by the top-level sequencer.
    localparam int PREWASH_SEC  = 300;
    localparam int WASH_SEC     = 2400;
    localparam int RINSE_SEC    = 900;
    localparam int DRY_SEC      = 1800;

endpackage

// File: rtl/wash_countdown_timer_if.sv
// Control/status bundle between the phase sequencer (master) and the countdown timer (slave).
// Optional `warn` status exists only when WASH_TIMER_WARN_EN is defined.
interface wash_countdown_timer_if #(
    parameter int SEC_W = wash_pkg::SEC_W_DEF
);
    logic             tick;
    logic             load;
    logic [SEC_W-1:0] load_sec;
    logic             start;
    logic             pause;
    logic             abort;
    logic             tick_en;
    logic             running;
    logic             paused;
    logic             done;
    logic [SEC_W-1:0] remain_sec;
    logic [6:0]       disp_min;
    logic [5:0]       disp_sec;
`ifdef WASH_TIMER_WARN_EN
    logic             warn;
`endif

    modport master (
        output tick, load, load_sec, start, pause, abort,
        input  tick_en, running, paused, done, remain_sec, disp_min, disp_sec
`ifdef WASH_TIMER_WARN_EN
        , input warn
`endif
    );

    modport slave (
        input  tick, load, load_sec, start, pause, abort,
        output tick_en, running, paused, done, remain_sec, disp_min, disp_sec
`ifdef WASH_TIMER_WARN_EN
        , output warn
`endif
    );

endinterface

// File: rtl/wash_countdown_timer_sec_to_mmss.sv
// Seconds to minutes:seconds converter, one registered cycle of latency, no backpressure.
// Constant divide by 60 settles combinationally within the cycle.
module sec_to_mmss
    import wash_pkg::*;
#(
    parameter int SEC_W = SEC_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [SEC_W-1:0] sec,
    output logic [6:0]       disp_min,
    output logic [5:0]       disp_sec
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_min <= '0;
            disp_sec <= '0;
        end else begin
            disp_min <= 7'(sec / SEC_W'(SEC_PER_MIN));
            disp_sec <= 6'(sec % SEC_W'(SEC_PER_MIN));
        end
    end

endmodule

// File: rtl/wash_countdown_timer.sv
// Loadable seconds countdown per wash phase; remain_sec updates on the tick edge, display one cycle later.
// No backpressure: commands are level-sampled each cycle; `warn` added when WASH_TIMER_WARN_EN is defined.
module wash_countdown_timer
    import wash_pkg::*;
#(
    parameter int MAX_SEC = MAX_SEC_DEF,
    parameter int SEC_W   = $clog2(MAX_SEC + 1)
`ifdef WASH_TIMER_WARN_EN
    , parameter int WARN_SEC = WARN_SEC_DEF
`endif
) (
    input  logic                   clk,
    input  logic                   reset_n,
    wash_countdown_timer_if.slave  bus
);

    state_t           state;
    logic [SEC_W-1:0] remain;
    logic             done_q;
    logic             load_ok;
    logic [SEC_W-1:0] load_val;

    // Loads during an active countdown are dropped so they cannot block start/pause/tick.
    assign load_ok  = bus.load && ((state == ST_IDLE) || (state == ST_DONE));
    assign load_val = (bus.load_sec > SEC_W'(MAX_SEC)) ? SEC_W'(MAX_SEC) : bus.load_sec;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            remain <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.abort) begin
                state  <= ST_IDLE;
                remain <= '0;
            end else if (load_ok) begin
                state  <= ST_IDLE;
                remain <= load_val;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            if (remain == '0) begin
                                state  <= ST_DONE;
                                done_q <= 1'b1;
                            end else begin
                                state  <= ST_RUN;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (bus.pause) begin
                            state <= ST_PAUSE;
                        end else if (bus.tick) begin
                            if (remain <= SEC_W'(1)) begin
                                remain <= '0;
                                state  <= ST_DONE;
                                done_q <= 1'b1;
                            end else begin
                                remain <= remain - SEC_W'(1);
                            end
                        end
                    end
                    ST_PAUSE: begin
                        if (bus.start) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_DONE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Enable drops outside RUN so the tick generator restarts its phase on resume.
    assign bus.tick_en    = (state == ST_RUN);
    assign bus.running    = (state == ST_RUN);
    assign bus.paused     = (state == ST_PAUSE);
    assign bus.done       = done_q;
    assign bus.remain_sec = remain;

`ifdef WASH_TIMER_WARN_EN
    assign bus.warn = (state == ST_RUN) && (remain != '0) && (remain <= SEC_W'(WARN_SEC));
`endif

    sec_to_mmss #(
        .SEC_W (SEC_W)
    ) u_mmss (
        .clk      (clk),
        .reset_n  (reset_n),
        .sec      (remain),
        .disp_min (bus.disp_min),
        .disp_sec (bus.disp_sec)
    );

endmodule

// File: tb/tb_wash_countdown_timer.sv
// Scoreboard bench for wash_countdown_timer: each driven cycle queues its expected outputs,
// a monitor pops and compares them shortly after the clock edge.
module tb_wash_countdown_timer;
    localparam int SEC_W = 13;

    typedef struct {
        string tag;
        int    rem;
        int    st;
        bit    dn;
        int    dmin;
        int    dsec;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   n_vec = 0;
    int   n_err = 0;
    int   last_rem = 0;
    exp_t sb[$];

    wash_countdown_timer_if #(.SEC_W(SEC_W)) bus ();

    wash_countdown_timer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // est: 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE. Display lags remain by one cycle.
    task automatic step(input string tag, input bit tk, input bit ld, input bit st,
                        input bit ps, input bit ab, input int lsec,
                        input int erem, input int est, input bit edn);
        exp_t e;
        bus.tick     = tk;
        bus.load     = ld;
        bus.start    = st;
        bus.pause    = ps;
        bus.abort    = ab;
        bus.load_sec = SEC_W'(lsec);
        e.tag  = tag;
        e.rem  = erem;
        e.st   = est;
        e.dn   = edn;
        e.dmin = last_rem / 60;
        e.dsec = last_rem % 60;
        sb.push_back(e);
        last_rem = erem;
        @(posedge clk);
        #5;
    endtask

    task automatic idle(input string tag, input int erem, input int est);
        step(tag, 0, 0, 0, 0, 0, 0, erem, est, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rem"},   int'(bus.remain_sec), 0);
        chk({tag, "_run"},   int'(bus.running),    0);
        chk({tag, "_pau"},   int'(bus.paused),     0);
        chk({tag, "_ten"},   int'(bus.tick_en),    0);
        chk({tag, "_done"},  int'(bus.done),       0);
        chk({tag, "_dmin"},  int'(bus.disp_min),   0);
        chk({tag, "_dsec"},  int'(bus.disp_sec),   0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, "_rem"},  int'(bus.remain_sec), e.rem);
            chk({e.tag, "_run"},  int'(bus.running),    int'(e.st == 1));
            chk({e.tag, "_pau"},  int'(bus.paused),     int'(e.st == 2));
            chk({e.tag, "_ten"},  int'(bus.tick_en),    int'(e.st == 1));
            chk({e.tag, "_done"}, int'(bus.done),       int'(e.dn));
            chk({e.tag, "_dmin"}, int'(bus.disp_min),   e.dmin);
            chk({e.tag, "_dsec"}, int'(bus.disp_sec),   e.dsec);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        bus.tick     = 1'b0;
        bus.load     = 1'b0;
        bus.start    = 1'b0;
        bus.pause    = 1'b0;
        bus.abort    = 1'b0;
        bus.load_sec = '0;
        #3;
        chk_reset_vals("reset");
        @(posedge clk);
        @(posedge clk);
        #5;
        reset_n = 1'b1;

        // 1: 65 s countdown, done one cycle after the last tick
        step("t1_load", 0, 1, 0, 0, 0, 65, 65, 0, 0);
        step("t1_start", 0, 0, 1, 0, 0, 0, 65, 1, 0);
        for (int i = 1; i <= 65; i++)
            step($sformatf("t1_tick%0d", i), 1, 0, 0, 0, 0, 0, 65 - i,
                 (i == 65) ? 3 : 1, i == 65);
        idle("t1_hold", 0, 3);
        step("t1_start_in_done", 0, 0, 1, 0, 0, 0, 0, 3, 0);

        // 2: pause with coincident tick drops that tick
        step("t2_load", 0, 1, 0, 0, 0, 10, 10, 0, 0);
        step("t2_start", 0, 0, 1, 0, 0, 0, 10, 1, 0);
        for (int i = 1; i <= 3; i++)
            step($sformatf("t2_tick%0d", i), 1, 0, 0, 0, 0, 0, 10 - i, 1, 0);
        step("t2_pause_tick", 1, 0, 0, 1, 0, 0, 7, 2, 0);
        for (int i = 1; i <= 5; i++)
            step($sformatf("t2_ptick%0d", i), 1, 0, 0, 0, 0, 0, 7, 2, 0);
        step("t2_load_in_pause", 0, 1, 0, 0, 0, 50, 7, 2, 0);
        step("t2_resume", 0, 0, 1, 0, 0, 0, 7, 1, 0);
        for (int i = 1; i <= 7; i++)
            step($sformatf("t2_tick_r%0d", i), 1, 0, 0, 0, 0, 0, 7 - i,
                 (i == 7) ? 3 : 1, i == 7);
        idle("t2_hold", 0, 3);

        // 3: saturating load
        step("t3_load8000", 0, 1, 0, 0, 0, 8000, 5999, 0, 0);
        idle("t3_disp", 5999, 0);
        step("t3_load6000", 0, 1, 0, 0, 0, 6000, 5999, 0, 0);
        step("t3_load5998", 0, 1, 0, 0, 0, 5998, 5998, 0, 0);
        step("t3_abort", 0, 0, 0, 0, 1, 0, 0, 0, 0);

        // 4: start with zero goes straight to DONE, only one pulse
        step("t4_load0", 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step("t4_start", 0, 0, 1, 0, 0, 0, 0, 3, 1);
        idle("t4_after", 0, 3);
        step("t4_restart", 0, 0, 1, 0, 0, 0, 0, 3, 0);
        idle("t4_quiet", 0, 3);

        // 5: load ignored in RUN, abort beats load
        step("t5_load", 0, 1, 0, 0, 0, 30, 30, 0, 0);
        step("t5_tick_idle", 1, 0, 0, 0, 0, 0, 30, 0, 0);
        step("t5_start", 0, 0, 1, 0, 0, 0, 30, 1, 0);
        for (int i = 1; i <= 4; i++)
            step($sformatf("t5_tick%0d", i), 1, 0, 0, 0, 0, 0, 30 - i, 1, 0);
        step("t5_load_in_run", 0, 1, 0, 0, 0, 99, 26, 1, 0);
        step("t5_abort_load", 0, 1, 0, 0, 1, 40, 0, 0, 0);
        idle("t5_after", 0, 0);
        step("t5_tick_after", 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // 6: asynchronous reset mid-run
        step("t6_load", 0, 1, 0, 0, 0, 20, 20, 0, 0);
        step("t6_start", 0, 0, 1, 0, 0, 0, 20, 1, 0);
        for (int i = 1; i <= 3; i++)
            step($sformatf("t6_tick%0d", i), 1, 0, 0, 0, 0, 0, 20 - i, 1, 0);
        idle("t6_at17", 17, 1);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("t6_async");
        @(posedge clk);
        @(posedge clk);
        #5;
        reset_n  = 1'b1;
        last_rem = 0;
        for (int i = 1; i <= 3; i++)
            step($sformatf("t6_dead_tick%0d", i), 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("t6_reload", 0, 1, 0, 0, 0, 2, 2, 0, 0);
        step("t6_restart", 0, 0, 1, 0, 0, 0, 2, 1, 0);
        step("t6_tick_a", 1, 0, 0, 0, 0, 0, 1, 1, 0);
        step("t6_tick_b", 1, 0, 0, 0, 0, 0, 0, 3, 1);
        idle("t6_end", 0, 3);

        @(posedge clk);
        #5;
        chk("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
